// File: rtl/input_selector_seq.sv
// ---------------------------------------------------------------------------
// input_selector_seq
// Sequential, multi-operand input selector. A start request latches one
// selection descriptor per operand (origin bit, main index, regs index).
// The block then fetches one operand per cycle from the main input bus or
// the register-bank bus and packs it into a registered output word. The
// word is presented with a valid/ack handshake.
//
// Ports
//   clk           in  rising-edge clock
//   reset_L       in  synchronous reset, active-low
//   wStart        in  fetch request (taken in IDLE, or in DONE together with wAck)
//   wHold         in  stall, no fetch this cycle
//   wBusy         in  forces main-input origin for the fetch in this cycle
//   wSelecOrigin  in  bit k: 0=main, 1=regs for operand k
//   wSelecMain    in  field k: main index of operand k
//   wSelecRegs    in  field k: regs index of operand k
//   wData         in  main data bus, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wDataRegs     in  register-bank data bus, same packing
//   wAck          in  consumer accepts r while rValid=1
//   r             out packed operands, operand k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rValid        out r complete and stable
//   rBusy         out high exactly while fetching
// ---------------------------------------------------------------------------
module input_selector_seq #(
  parameter int DATA_WIDTH  = 4,
  parameter int MAIN_INPUTS = 16,
  parameter int REGS_INPUTS = 64,
  parameter int OPERANDS    = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_L,
  input  logic                                      wStart,
  input  logic                                      wHold,
  input  logic                                      wBusy,
  input  logic [OPERANDS-1:0]                       wSelecOrigin,
  input  logic [OPERANDS*$clog2(MAIN_INPUTS)-1:0]   wSelecMain,
  input  logic [OPERANDS*$clog2(REGS_INPUTS)-1:0]   wSelecRegs,
  input  logic [MAIN_INPUTS*DATA_WIDTH-1:0]         wData,
  input  logic [REGS_INPUTS*DATA_WIDTH-1:0]         wDataRegs,
  input  logic                                      wAck,
  output logic [OPERANDS*DATA_WIDTH-1:0]            r,
  output logic                                      rValid,
  output logic                                      rBusy
);

  localparam int MAIN_IDX_W = $clog2(MAIN_INPUTS);
  localparam int REGS_IDX_W = $clog2(REGS_INPUTS);
  localparam int IDX_W      = (OPERANDS > 1) ? $clog2(OPERANDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OPERANDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                               r_state;
  logic [IDX_W-1:0]                     r_idx;
  logic [OPERANDS-1:0]                  r_origin;
  logic [OPERANDS*MAIN_IDX_W-1:0]       r_sel_main;
  logic [OPERANDS*REGS_IDX_W-1:0]       r_sel_regs;

  logic [MAIN_IDX_W-1:0]                w_cur_main_idx;
  logic [REGS_IDX_W-1:0]                w_cur_regs_idx;
  logic                                 w_cur_origin;
  logic [DATA_WIDTH-1:0]                w_main_word;
  logic [DATA_WIDTH-1:0]                w_regs_word;
  logic [DATA_WIDTH-1:0]                w_fetch_word;
  logic [OPERANDS*DATA_WIDTH-1:0]       w_r_next;

  // Descriptor of the operand currently being fetched, plus live origin override.
  always_comb begin
    w_cur_main_idx = r_sel_main[r_idx*MAIN_IDX_W +: MAIN_IDX_W];
    w_cur_regs_idx = r_sel_regs[r_idx*REGS_IDX_W +: REGS_IDX_W];
    // wBusy is the live value: it only overrides the fetch of this cycle.
    w_cur_origin   = r_origin[r_idx] & ~wBusy;
  end

  // AND-OR word multiplexers; an index with no matching word yields zero.
  always_comb begin
    w_main_word = {DATA_WIDTH{1'b0}};
    w_regs_word = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < MAIN_INPUTS; i++) begin
      w_main_word = w_main_word |
        ({DATA_WIDTH{w_cur_main_idx == i[MAIN_IDX_W-1:0]}} & wData[i*DATA_WIDTH +: DATA_WIDTH]);
    end
    for (int j = 0; j < REGS_INPUTS; j++) begin
      w_regs_word = w_regs_word |
        ({DATA_WIDTH{w_cur_regs_idx == j[REGS_IDX_W-1:0]}} & wDataRegs[j*DATA_WIDTH +: DATA_WIDTH]);
    end
    w_fetch_word = w_cur_origin ? w_regs_word : w_main_word;
  end

  // Next output word: only the slot at the current index is replaced.
  always_comb begin
    w_r_next = r;
    for (int k = 0; k < OPERANDS; k++) begin
      w_r_next[k*DATA_WIDTH +: DATA_WIDTH] =
        (r_idx == k[IDX_W-1:0]) ? w_fetch_word : r[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Control FSM with registered outputs and descriptor latches.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state    <= S_IDLE;
      r_idx      <= {IDX_W{1'b0}};
      r_origin   <= {OPERANDS{1'b0}};
      r_sel_main <= {(OPERANDS*MAIN_IDX_W){1'b0}};
      r_sel_regs <= {(OPERANDS*REGS_IDX_W){1'b0}};
      r          <= {(OPERANDS*DATA_WIDTH){1'b0}};
      rValid     <= 1'b0;
      rBusy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wStart) begin
            r_origin   <= wSelecOrigin;
            r_sel_main <= wSelecMain;
            r_sel_regs <= wSelecRegs;
            r_idx      <= {IDX_W{1'b0}};
            r_state    <= S_FETCH;
            rBusy      <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!wHold) begin
            r <= w_r_next;
            if (r_idx == LAST_IDX) begin
              r_idx   <= {IDX_W{1'b0}};
              r_state <= S_DONE;
              rBusy   <= 1'b0;
              rValid  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          // wStart only counts when it comes with the acknowledge.
          if (wAck) begin
            rValid <= 1'b0;
            if (wStart) begin
              r_origin   <= wSelecOrigin;
              r_sel_main <= wSelecMain;
              r_sel_regs <= wSelecRegs;
              r_idx      <= {IDX_W{1'b0}};
              r_state    <= S_FETCH;
              rBusy      <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= {IDX_W{1'b0}};
          rValid  <= 1'b0;
          rBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_selector_seq.sv
// ---------------------------------------------------------------------------
// tb_input_selector_seq
// Directed testbench for input_selector_seq (DW=4, MAIN=16, REGS=64, OPS=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_input_selector_seq;

  logic         clk;
  logic         reset_L;
  logic         wStart;
  logic         wHold;
  logic         wBusy;
  logic [1:0]   wSelecOrigin;
  logic [7:0]   wSelecMain;
  logic [11:0]  wSelecRegs;
  logic [63:0]  wData;
  logic [255:0] wDataRegs;
  logic         wAck;
  logic [7:0]   r;
  logic         rValid;
  logic         rBusy;

  int checks;
  int errors;

  input_selector_seq #(
    .DATA_WIDTH (4),
    .MAIN_INPUTS(16),
    .REGS_INPUTS(64),
    .OPERANDS   (2)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .wStart      (wStart),
    .wHold       (wHold),
    .wBusy       (wBusy),
    .wSelecOrigin(wSelecOrigin),
    .wSelecMain  (wSelecMain),
    .wSelecRegs  (wSelecRegs),
    .wData       (wData),
    .wDataRegs   (wDataRegs),
    .wAck        (wAck),
    .r           (r),
    .rValid      (rValid),
    .rBusy       (rBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    tick();
    tick();
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("FAIL reset_r got %h want %h", r, 8'h00);
    end
    checks++;
    if ({rBusy, rValid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got %b want %b", {rBusy, rValid}, 2'b00);
    end
    reset_L = 1'b1;
    tick();
  endtask

  // Case 1: main fetch, words 3 and 5 -> 8'h7A, held until wAck.
  task automatic test_main_fetch();
    wData[3*4 +: 4] = 4'hA;
    wData[5*4 +: 4] = 4'h7;
    wSelecOrigin = 2'b00;
    wSelecMain   = {4'd5, 4'd3};
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    checks++;
    if ({rBusy, rValid} !== 2'b10) begin
      errors++;
      $display("FAIL main_busy1 got %b want %b", {rBusy, rValid}, 2'b10);
    end
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b10) begin
      errors++;
      $display("FAIL main_busy2 got %b want %b", {rBusy, rValid}, 2'b10);
    end
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b01 || r !== 8'h7A) begin
      errors++;
      $display("FAIL main_done got flags %b r %h want 01 7a", {rBusy, rValid}, r);
    end
    // Result must stay frozen in DONE even though the source word changes.
    wData[3*4 +: 4] = 4'hF;
    tick();
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b01 || r !== 8'h7A) begin
      errors++;
      $display("FAIL main_hold got flags %b r %h want 01 7a", {rBusy, rValid}, r);
    end
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
    checks++;
    if ({rBusy, rValid} !== 2'b00) begin
      errors++;
      $display("FAIL main_ack got %b want %b", {rBusy, rValid}, 2'b00);
    end
    wData[3*4 +: 4] = 4'hA;
  endtask

  // Case 2: regs fetch -> 8'h2C; wBusy forces main; wBusy on one cycle only.
  task automatic test_regs_fetch();
    wDataRegs[40*4 +: 4] = 4'hC;
    wDataRegs[1*4 +: 4]  = 4'h2;
    wSelecOrigin = 2'b11;
    wSelecRegs   = {6'd1, 6'd40};
    wSelecMain   = {4'd5, 4'd3};
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    tick();
    tick();
    checks++;
    if (rValid !== 1'b1 || r !== 8'h2C) begin
      errors++;
      $display("FAIL regs_result got valid %b r %h want 1 2c", rValid, r);
    end
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
    wBusy = 1'b1;
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    tick();
    tick();
    checks++;
    if (rValid !== 1'b1 || r !== 8'h7A) begin
      errors++;
      $display("FAIL regs_busy_all got valid %b r %h want 1 7a", rValid, r);
    end
    wBusy = 1'b0;
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
    // wBusy only during the second fetch: slot0 from regs, slot1 from main.
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    tick();
    wBusy = 1'b1;
    tick();
    wBusy = 1'b0;
    checks++;
    if (rValid !== 1'b1 || r !== 8'h7C) begin
      errors++;
      $display("FAIL regs_busy_one got valid %b r %h want 1 7c", rValid, r);
    end
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
  endtask

  // Case 3: 3 hold cycles after slot0 -> valid 3 cycles later.
  task automatic test_stall();
    wData[2*4 +: 4] = 4'h1;
    wData[6*4 +: 4] = 4'h9;
    wSelecOrigin = 2'b00;
    wSelecMain   = {4'd6, 4'd2};
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    tick();
    wHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rBusy, rValid} !== 2'b10) begin
        errors++;
        $display("FAIL stall_hold%0d got %b want %b", i, {rBusy, rValid}, 2'b10);
      end
    end
    wHold = 1'b0;
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b01 || r !== 8'h91) begin
      errors++;
      $display("FAIL stall_done got flags %b r %h want 01 91", {rBusy, rValid}, r);
    end
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
  endtask

  // Case 4: ack+start in DONE restarts at once; wStart in FETCH/DONE ignored.
  task automatic test_back_to_back();
    wSelecOrigin = 2'b00;
    wSelecMain   = {4'd5, 4'd3};
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    tick();
    tick();
    checks++;
    if (rValid !== 1'b1 || r !== 8'h7A) begin
      errors++;
      $display("FAIL b2b_first got valid %b r %h want 1 7a", rValid, r);
    end
    wSelecOrigin = 2'b11;
    wSelecRegs   = {6'd1, 6'd40};
    wAck = 1'b1;
    wStart = 1'b1;
    tick();
    wAck = 1'b0;
    wStart = 1'b0;
    checks++;
    if ({rBusy, rValid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_restart got %b want %b", {rBusy, rValid}, 2'b10);
    end
    tick();
    wStart = 1'b1;
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b01 || r !== 8'h2C) begin
      errors++;
      $display("FAIL b2b_second got flags %b r %h want 01 2c", {rBusy, rValid}, r);
    end
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_start_no_ack got %b want %b", {rBusy, rValid}, 2'b01);
    end
    wStart = 1'b0;
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle got %b want %b", {rBusy, rValid}, 2'b00);
    end
  endtask

  // Case 5: reset after slot0 written, then a normal request.
  task automatic test_reset_mid_fetch();
    wSelecOrigin = 2'b00;
    wSelecMain   = {4'd5, 4'd3};
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    tick();
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    checks++;
    if (r !== 8'h00 || {rBusy, rValid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_clear got flags %b r %h want 00 00", {rBusy, rValid}, r);
    end
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_idle got %b want %b", {rBusy, rValid}, 2'b00);
    end
    wSelecOrigin = 2'b11;
    wSelecRegs   = {6'd1, 6'd40};
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    tick();
    tick();
    checks++;
    if ({rBusy, rValid} !== 2'b01 || r !== 8'h2C) begin
      errors++;
      $display("FAIL midrst_new got flags %b r %h want 01 2c", {rBusy, rValid}, r);
    end
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
  endtask

  // Case 6: select inputs changing during FETCH have no effect.
  task automatic test_latch();
    wSelecOrigin = 2'b00;
    wSelecMain   = {4'd5, 4'd3};
    wStart = 1'b1;
    tick();
    wStart = 1'b0;
    wSelecOrigin = 2'b11;
    wSelecMain   = {4'd2, 4'd6};
    wSelecRegs   = {6'd40, 6'd1};
    tick();
    tick();
    checks++;
    if (rValid !== 1'b1 || r !== 8'h7A) begin
      errors++;
      $display("FAIL latch_result got valid %b r %h want 1 7a", rValid, r);
    end
    wAck = 1'b1;
    tick();
    wAck = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_L      = 1'b0;
    wStart       = 1'b0;
    wHold        = 1'b0;
    wBusy        = 1'b0;
    wAck         = 1'b0;
    wSelecOrigin = 2'b00;
    wSelecMain   = 8'h00;
    wSelecRegs   = 12'h000;
    wData        = 64'h0;
    wDataRegs    = 256'h0;

    test_reset();
    test_main_fetch();
    test_regs_fetch();
    test_stall();
    test_back_to_back();
    test_reset_mid_fetch();
    test_latch();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
